dht11_read_manager: RTL

Transaction layer between the command interface and the DHT11 single-wire sampling FSM. Accepts one read request at a time and enforces the sensor's minimum interval between reads. Pulses the sensor FSM's `start_bit`, then consumes its `done`/`errorSensor` and 40-bit result. Verifies the checksum, retries failed reads, and returns a single coded response word to the downstream transmitter.

---
 rtl/dht_pkg.sv | 46 ++++
 rtl/dht_holdoff_timer.sv | 47 ++++
 rtl/dht11_read_manager.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 read manager: command encodings,
// response codes, the transaction state enum and the checksum helper.
package dht_pkg;

   // Command field carried with each read request.
   typedef enum logic [1:0] {
      CMD_STATUS  = 2'b00,
      CMD_HUM     = 2'b01,
      CMD_TEMP    = 2'b10,
      CMD_INVALID = 2'b11
   } dht_cmd_e;

   // Response codes returned to the downstream transmitter.
   localparam logic [7:0] RSP_STATUS     = 8'h00;
   localparam logic [7:0] RSP_HUM        = 8'h01;
   localparam logic [7:0] RSP_TEMP       = 8'h02;
   localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
   localparam logic [7:0] RSP_CKSUM_ERR  = 8'h2F;
   localparam logic [7:0] RSP_TIMEOUT    = 8'h3F;
   localparam logic [7:0] RSP_BAD_CMD    = 8'hEE;

   // Transaction states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HOLDOFF   = 3'd1,
      ST_TRIGGER   = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CHECK     = 3'd4,
      ST_RESPOND   = 3'd5
   } dht_state_e;

   // DHT11 checksum: modulo-256 sum of the four data bytes.
   function automatic logic [7:0] dht_checksum(
      input logic [7:0] hum_i,
      input logic [7:0] hum_f,
      input logic [7:0] tmp_i,
      input logic [7:0] tmp_f
   );
      logic [7:0] sum_s;
      sum_s = hum_i + hum_f;
      sum_s = sum_s + tmp_i;
      sum_s = sum_s + tmp_f;
      return sum_s;
   endfunction

endpackage

// File: rtl/dht_holdoff_timer.sv
// Saturating interval counter between sensor trigger pulses.
// Cleared by the trigger pulse (and by reset, so the first read after reset
// waits the full interval). Saturates at MIN_INTERVAL_US.
// 'elapsed' is registered and asserts one cycle before the count reaches
// MIN_INTERVAL_US, because the trigger it gates is itself a registered
// output: a decision taken while 'elapsed' is high puts start_bit on the
// following cycle, exactly MIN_INTERVAL_US cycles after reset release.
module dht_holdoff_timer #(
   parameter int MIN_INTERVAL_US = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic elapsed
);

   localparam int CW = (MIN_INTERVAL_US > 1) ? $clog2(MIN_INTERVAL_US + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MIN_INTERVAL_US);
   localparam logic [CW-1:0] CNT_ARM = CW'(MIN_INTERVAL_US - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;

   // Next count: clear on trigger, otherwise count up and saturate.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear) begin
         cnt_next_s = {CW{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
         cnt_next_s = cnt_r + CW'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Count register and registered elapsed flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CW{1'b0}};
         elapsed <= 1'b0;
      end else begin
         cnt_r   <= cnt_next_s;
         elapsed <= (cnt_next_s >= CNT_ARM);
      end
   end

endmodule

// File: rtl/dht11_read_manager.sv
// DHT11 read manager: accepts one read request at a time, spaces sensor
// triggers by at least MIN_INTERVAL_US cycles, waits for the sensor FSM
// result with a timeout, retries failed reads up to MAX_RETRIES times and
// returns a single coded response word.
// Optional feature: define DHT_CKSUM_CHECK_EN to compare the sensor checksum
// byte; without it check_sum is ignored and no checksum comparator exists.
module dht11_read_manager
   import dht_pkg::*;
#(
   parameter int MIN_INTERVAL_US = 1_000_000,
   parameter int TIMEOUT_US      = 30_000,
   parameter int MAX_RETRIES     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   output logic        start_bit,
   input  logic        sensor_done,
   input  logic        sensor_error,
   input  logic [7:0]  hum_int,
   input  logic [7:0]  hum_float,
   input  logic [7:0]  temp_int,
   input  logic [7:0]  temp_float,
   input  logic [7:0]  check_sum,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_code,
   output logic [15:0] rsp_data
);

   localparam int WW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US + 1) : 1;
   localparam logic [WW-1:0] WAIT_LIMIT  = WW'(TIMEOUT_US);
   localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRIES);

   dht_state_e    state_r;
   dht_cmd_e      cmd_r;
   logic [2:0]    attempts_r;
   logic [WW-1:0] wait_cnt_r;
   logic          timed_out_r;
   logic          sensor_err_r;
   logic [7:0]    hum_int_r;
   logic [7:0]    hum_float_r;
   logic [7:0]    temp_int_r;
   logic [7:0]    temp_float_r;

   logic          elapsed_s;
   logic          cksum_bad_s;
   logic          fail_s;
   logic [7:0]    fail_code_s;
   logic [7:0]    ok_code_s;
   logic [15:0]   ok_data_s;

`ifdef DHT_CKSUM_CHECK_EN
   logic [7:0]    cksum_r;

   // Capture the sensor checksum byte together with the data bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cksum_r <= 8'h00;
      end else if ((state_r == ST_WAIT_DONE) && sensor_done) begin
         cksum_r <= check_sum;
      end else begin
         cksum_r <= cksum_r;
      end
   end
`else
   logic          cksum_unused_s;
   assign cksum_unused_s = ^check_sum;
`endif

   // Interval between consecutive trigger pulses; cleared by each pulse.
   dht_holdoff_timer #(
      .MIN_INTERVAL_US (MIN_INTERVAL_US)
   ) u_holdoff (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start_bit),
      .elapsed (elapsed_s)
   );

   // Checksum comparison on the latched result bytes.
   always_comb begin
`ifdef DHT_CKSUM_CHECK_EN
      cksum_bad_s = (dht_checksum(hum_int_r, hum_float_r, temp_int_r, temp_float_r) != cksum_r);
`else
      cksum_bad_s = 1'b0;
`endif
   end

   // Failure classification: timeout, then sensor error, then checksum.
   always_comb begin
      fail_s      = 1'b0;
      fail_code_s = RSP_STATUS;
      if (timed_out_r) begin
         fail_s      = 1'b1;
         fail_code_s = RSP_TIMEOUT;
      end else if (sensor_err_r) begin
         fail_s      = 1'b1;
         fail_code_s = RSP_SENSOR_ERR;
      end else if (cksum_bad_s) begin
         fail_s      = 1'b1;
         fail_code_s = RSP_CKSUM_ERR;
      end else begin
         fail_s      = 1'b0;
         fail_code_s = RSP_STATUS;
      end
   end

   // Success response word selected by the latched command.
   always_comb begin
      ok_code_s = RSP_STATUS;
      ok_data_s = 16'h0000;
      case (cmd_r)
         CMD_STATUS: begin
            ok_code_s = RSP_STATUS;
            ok_data_s = {hum_int_r, temp_int_r};
         end
         CMD_HUM: begin
            ok_code_s = RSP_HUM;
            ok_data_s = {hum_int_r, hum_float_r};
         end
         CMD_TEMP: begin
            ok_code_s = RSP_TEMP;
            ok_data_s = {temp_int_r, temp_float_r};
         end
         default: begin
            ok_code_s = RSP_BAD_CMD;
            ok_data_s = 16'h0000;
         end
      endcase
   end

   // Transaction FSM with registered handshake, trigger and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cmd_r        <= CMD_STATUS;
         attempts_r   <= 3'd0;
         wait_cnt_r   <= {WW{1'b0}};
         timed_out_r  <= 1'b0;
         sensor_err_r <= 1'b0;
         hum_int_r    <= 8'h00;
         hum_float_r  <= 8'h00;
         temp_int_r   <= 8'h00;
         temp_float_r <= 8'h00;
         req_ready    <= 1'b0;
         start_bit    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_code     <= 8'h00;
         rsp_data     <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready  <= 1'b0;
                  cmd_r      <= dht_cmd_e'(req_cmd);
                  attempts_r <= 3'd0;
                  if (req_cmd == CMD_INVALID) begin
                     state_r   <= ST_RESPOND;
                     rsp_valid <= 1'b1;
                     rsp_code  <= RSP_BAD_CMD;
                     rsp_data  <= 16'h0000;
                  end else if (elapsed_s) begin
                     state_r   <= ST_TRIGGER;
                     start_bit <= 1'b1;
                  end else begin
                     state_r   <= ST_HOLDOFF;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end

            ST_HOLDOFF: begin
               if (elapsed_s) begin
                  state_r   <= ST_TRIGGER;
                  start_bit <= 1'b1;
               end
            end

            ST_TRIGGER: begin
               // start_bit is high for exactly this cycle.
               start_bit   <= 1'b0;
               wait_cnt_r  <= WW'(1);
               timed_out_r <= 1'b0;
               state_r     <= ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
               // A done pulse on the timeout cycle still counts as done.
               if (sensor_done) begin
                  sensor_err_r <= sensor_error;
                  hum_int_r    <= hum_int;
                  hum_float_r  <= hum_float;
                  temp_int_r   <= temp_int;
                  temp_float_r <= temp_float;
                  timed_out_r  <= 1'b0;
                  state_r      <= ST_CHECK;
               end else if (wait_cnt_r >= WAIT_LIMIT) begin
                  timed_out_r  <= 1'b1;
                  state_r      <= ST_CHECK;
               end else begin
                  wait_cnt_r   <= wait_cnt_r + WW'(1);
               end
            end

            ST_CHECK: begin
               if (fail_s) begin
                  if (attempts_r < RETRY_LIMIT) begin
                     attempts_r <= attempts_r + 3'd1;
                     state_r    <= ST_HOLDOFF;
                  end else begin
                     state_r    <= ST_RESPOND;
                     rsp_valid  <= 1'b1;
                     rsp_code   <= fail_code_s;
                     rsp_data   <= {8'h00, 5'b00000, attempts_r};
                  end
               end else begin
                  state_r   <= ST_RESPOND;
                  rsp_valid <= 1'b1;
                  rsp_code  <= ok_code_s;
                  rsp_data  <= ok_data_s;
               end
            end

            ST_RESPOND: begin
               // Code and data stay frozen until the consumer takes them.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_r   <= ST_IDLE;
               end
            end

            default: begin
               state_r   <= ST_IDLE;
               req_ready <= 1'b0;
               start_bit <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
